// File: rtl/vga_pattern_gen_if.sv
// Control and video bundle of the VGA test-pattern source.
// The generator is master (drives video); the controller/sink is slave.
interface vga_pattern_gen_if #(
   parameter int COLOR_W = 4
);
   logic               pix_ce;
   logic [2:0]         mode;
   logic               freeze;
   logic               VGA_HS;
   logic               VGA_VS;
   logic [COLOR_W-1:0] VGA_R;
   logic [COLOR_W-1:0] VGA_G;
   logic [COLOR_W-1:0] VGA_B;
   logic               data_en;
   logic               frame_start;

   modport master (
      input  pix_ce, mode, freeze,
      output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
      output data_en, frame_start
   );

   modport slave (
      output pix_ce, mode, freeze,
      input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
      input  data_en, frame_start
   );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: timing counters, sync, colour
// sequencer and six patterns, all outputs registered.
module vga_pattern_gen #(
   parameter int COLOR_W     = 4,
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0,
   parameter int HOLD_FRAMES = 60,
   parameter int SCROLL_STEP = 1,
   parameter int CHECK_LOG2  = 5,
   parameter int GRAD_SHIFT  = 5
) (
   input  logic              clk,
   input  logic              rst,
   vga_pattern_gen_if.master vga
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam int FW      = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   localparam logic [COLOR_W-1:0] FS       = '1;
   localparam logic [HW-1:0]      H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0]      V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [BW-1:0]      BAR_LAST = BW'(BAR_W - 1);
   localparam logic [FW-1:0]      F_LAST   = FW'(HOLD_FRAMES - 1);

   logic [HW-1:0]      h_cnt;
   logic [VW-1:0]      v_cnt;
   logic [BW-1:0]      bar_px;
   logic [2:0]         bar_k;
   logic [FW-1:0]      frame_cnt;
   logic [1:0]         color_idx;
   logic [VW-1:0]      scroll;
   logic [2:0]         mode_q;
   logic [31:0]        hx;
   logic [31:0]        vy;
   logic [31:0]        band_y;
   logic [31:0]        scroll_nxt;
   logic               h_wrap;
   logic               f_wrap;
   logic               active;
   logic               hs_on;
   logic               vs_on;
   logic [COLOR_W-1:0] grad;
   logic [COLOR_W-1:0] pr;
   logic [COLOR_W-1:0] pg;
   logic [COLOR_W-1:0] pb;

   assign hx     = 32'(h_cnt);
   assign vy     = 32'(v_cnt);
   assign h_wrap = (h_cnt == H_LAST);
   assign f_wrap = h_wrap && (v_cnt == V_LAST);
   assign active = (hx < 32'(H_ACTIVE)) && (vy < 32'(V_ACTIVE));
   assign hs_on  = (hx >= 32'(H_ACTIVE + H_FP)) &&
                   (hx <  32'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_on  = (vy >= 32'(V_ACTIVE + V_FP)) &&
                   (vy <  32'(V_ACTIVE + V_FP + V_SYNC));
   assign grad   = COLOR_W'(h_cnt >> GRAD_SHIFT);

   // Scrolled line index and next scroll offset, both folded into V_ACTIVE
   always_comb begin
      band_y = vy + 32'(scroll);
      if (band_y >= 32'(V_ACTIVE))
         band_y = band_y - 32'(V_ACTIVE);
      scroll_nxt = 32'(scroll) + 32'(SCROLL_STEP);
      if (scroll_nxt >= 32'(V_ACTIVE))
         scroll_nxt = scroll_nxt - 32'(V_ACTIVE);
   end

   // Pixel/line counters plus bar-width counter (bar index without a divider)
   always_ff @(posedge clk) begin
      if (!rst) begin
         h_cnt  <= '0;
         v_cnt  <= '0;
         bar_px <= '0;
         bar_k  <= '0;
      end else if (vga.pix_ce) begin
         h_cnt <= h_wrap ? '0 : h_cnt + HW'(1);
         if (h_wrap)
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
         if (h_wrap) begin
            bar_px <= '0;
            bar_k  <= '0;
         end else if (bar_px == BAR_LAST) begin
            bar_px <= '0;
            bar_k  <= bar_k + 3'd1;
         end else begin
            bar_px <= bar_px + BW'(1);
         end
      end
   end

   // Frame-boundary sequencer: latch mode, hold/advance colour, scroll bands
   always_ff @(posedge clk) begin
      if (!rst) begin
         mode_q    <= '0;
         frame_cnt <= '0;
         color_idx <= '0;
         scroll    <= '0;
      end else if (vga.pix_ce && f_wrap) begin
         mode_q <= vga.mode;
         if (vga.mode != mode_q) begin
            frame_cnt <= '0;
            color_idx <= '0;
            scroll    <= '0;
         end else if (!vga.freeze) begin
            if (frame_cnt == F_LAST) begin
               frame_cnt <= '0;
               color_idx <= (color_idx == 2'd2) ? 2'd0 : color_idx + 2'd1;
            end else begin
               frame_cnt <= frame_cnt + FW'(1);
            end
            scroll <= VW'(scroll_nxt);
         end
      end
   end

   // Pattern colour for the current counter position
   always_comb begin
      pr = '0;
      pg = '0;
      pb = '0;
      case (mode_q)
         3'd0: begin
            pr = (color_idx == 2'd0) ? FS : '0;
            pg = (color_idx == 2'd1) ? FS : '0;
            pb = (color_idx == 2'd2) ? FS : '0;
         end
         3'd1: begin
            pr = {COLOR_W{~bar_k[1]}};
            pg = {COLOR_W{~bar_k[2]}};
            pb = {COLOR_W{~bar_k[0]}};
         end
         3'd2: begin
            if (band_y < 32'(V_ACTIVE / 3))
               pr = FS;
            else if (band_y < 32'(2 * V_ACTIVE / 3))
               pg = FS;
            else
               pb = FS;
         end
         3'd3: begin
            if (h_cnt[CHECK_LOG2] == v_cnt[CHECK_LOG2]) begin
               pr = FS;
               pg = FS;
               pb = FS;
            end
         end
         3'd4: begin
            pr = grad;
            pg = grad;
            pb = grad;
         end
         3'd5: begin
            pr = (color_idx == 2'd0) ? FS :
                 (color_idx == 2'd1) ? (FS >> 1) : '0;
            pg = pr;
            pb = pr;
         end
         default: ;
      endcase
   end

   // Registered video outputs; frame_start never outlives one clk
   always_ff @(posedge clk) begin
      if (!rst) begin
         vga.VGA_HS      <= ~HS_POL;
         vga.VGA_VS      <= ~VS_POL;
         vga.VGA_R       <= '0;
         vga.VGA_G       <= '0;
         vga.VGA_B       <= '0;
         vga.data_en     <= 1'b0;
         vga.frame_start <= 1'b0;
      end else begin
         vga.frame_start <= vga.pix_ce && f_wrap;
         if (vga.pix_ce) begin
            vga.VGA_HS  <= hs_on ? HS_POL : ~HS_POL;
            vga.VGA_VS  <= vs_on ? VS_POL : ~VS_POL;
            vga.data_en <= active;
            vga.VGA_R   <= active ? pr : '0;
            vga.VGA_G   <= active ? pg : '0;
            vga.VGA_B   <= active ? pb : '0;
         end
      end
   end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced 24x10 raster,
// checked against a pixel-index reference model.
module tb_vga_pattern_gen;
   localparam int CW    = 4;
   localparam int HA    = 16;
   localparam int HFP   = 2;
   localparam int HSW   = 3;
   localparam int HBP   = 3;
   localparam int VA    = 6;
   localparam int VFP   = 1;
   localparam int VSW   = 2;
   localparam int VBP   = 1;
   localparam bit HP    = 1'b0;
   localparam bit VP    = 1'b1;
   localparam int HOLD  = 2;
   localparam int STEP  = 1;
   localparam int CL    = 1;
   localparam int GS    = 1;
   localparam int HT    = HA + HFP + HSW + HBP;
   localparam int VT    = VA + VFP + VSW + VBP;
   localparam int FRAME = HT * VT;

   localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF,
      12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
   localparam logic [11:0] SEQ [7] = '{12'hF00, 12'hF00, 12'h0F0,
      12'h0F0, 12'h00F, 12'h00F, 12'hF00};
   localparam logic [11:0] FRZ [8] = '{12'hF00, 12'hF00, 12'h0F0,
      12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0, 12'h00F};
   localparam logic [15:0] RST_VEC = {~HP, ~VP, 2'b00, 12'h000};

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   vga_pattern_gen_if #(.COLOR_W(CW)) vif();

   vga_pattern_gen #(
      .COLOR_W(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW),
      .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW),
      .V_BP(VBP), .HS_POL(HP), .VS_POL(VP), .HOLD_FRAMES(HOLD),
      .SCROLL_STEP(STEP), .CHECK_LOG2(CL), .GRAD_SHIFT(GS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vga(vif)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] dut_vec();
      return {vif.VGA_HS, vif.VGA_VS, vif.data_en, vif.frame_start,
              vif.VGA_R, vif.VGA_G, vif.VGA_B};
   endfunction

   function automatic logic [11:0] dut_rgb();
      return {vif.VGA_R, vif.VGA_G, vif.VGA_B};
   endfunction

   // Colour of pixel (x,y) given the frame's mode and the number of
   // sequencer advances since the last clear.
   function automatic logic [11:0] ref_pixel(logic [2:0] m, int x,
                                             int y, int adv);
      int col;
      int scr;
      int yy;
      int lvl;
      col = (adv / HOLD) % 3;
      scr = (adv * STEP) % VA;
      case (m)
         3'd0: return (col == 0) ? 12'hF00 : (col == 1) ? 12'h0F0 : 12'h00F;
         3'd1: return BARS[x / (HA / 8)];
         3'd2: begin
            yy = (y + scr) % VA;
            return (yy < VA / 3) ? 12'hF00 :
                   (yy < 2 * VA / 3) ? 12'h0F0 : 12'h00F;
         end
         3'd3: return (((x >> CL) + (y >> CL)) % 2 == 0) ? 12'hFFF : 12'h000;
         3'd4: begin
            lvl = (x >> GS) % 16;
            return {lvl[3:0], lvl[3:0], lvl[3:0]};
         end
         3'd5: return (col == 0) ? 12'hFFF : (col == 1) ? 12'h777 : 12'h000;
         default: return 12'h000;
      endcase
   endfunction

   int          m_n = 0;
   int          m_adv = 0;
   logic [2:0]  m_mode = 3'd0;
   logic [15:0] exp_vec;

   // Reference: m_n = pixel-enable edges since reset -> linear pixel index
   always @(posedge clk) begin
      int p;
      int x;
      int y;
      logic de;
      logic [11:0] px;
      if (!rst) begin
         m_n = 0;
         m_adv = 0;
         m_mode = 3'd0;
         exp_vec = RST_VEC;
      end else if (vif.pix_ce) begin
         p  = m_n % FRAME;
         x  = p % HT;
         y  = p / HT;
         de = (x < HA) && (y < VA);
         px = de ? ref_pixel(m_mode, x, y, m_adv) : 12'h000;
         exp_vec = {(x >= HA + HFP && x < HA + HFP + HSW) ? HP : ~HP,
                    (y >= VA + VFP && y < VA + VFP + VSW) ? VP : ~VP,
                    de, (p == FRAME - 1), px};
         if (p == FRAME - 1) begin
            if (vif.mode != m_mode)
               m_adv = 0;
            else if (!vif.freeze)
               m_adv++;
            m_mode = vif.mode;
         end
         m_n++;
      end else begin
         exp_vec[12] = 1'b0;
      end
   end

   task automatic test_reset();
      rst = 1'b0;
      vif.pix_ce = 1'b1;
      vif.freeze = 1'b0;
      vif.mode = 3'($urandom_range(0, 7));
      repeat (3) @(negedge clk);
      n_chk++;
      if (dut_vec() !== RST_VEC) begin
         n_fail++;
         $display("FAIL reset: got %h want %h", dut_vec(), RST_VEC);
      end
      vif.mode = 3'd0;
   endtask

   task automatic test_timing();
      int hs_n = 0;
      int vs_n = 0;
      int de_n = 0;
      int red_n = 0;
      int fs_n = 0;
      rst = 1'b1;
      repeat (FRAME) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec() !== exp_vec) begin
            n_fail++;
            $display("FAIL timing: got %h want %h n=%0d", dut_vec(), exp_vec, m_n);
         end
         if (vif.VGA_HS == HP) hs_n++;
         if (vif.VGA_VS == VP) vs_n++;
         if (vif.data_en) de_n++;
         if (vif.data_en && dut_rgb() == 12'hF00) red_n++;
         if (vif.frame_start) fs_n++;
      end
      n_chk++;
      if (hs_n != HSW * VT) begin
         n_fail++;
         $display("FAIL hs_count: got %0d want %0d", hs_n, HSW * VT);
      end
      n_chk++;
      if (vs_n != VSW * HT) begin
         n_fail++;
         $display("FAIL vs_count: got %0d want %0d", vs_n, VSW * HT);
      end
      n_chk++;
      if (de_n != HA * VA) begin
         n_fail++;
         $display("FAIL de_count: got %0d want %0d", de_n, HA * VA);
      end
      n_chk++;
      if (red_n != HA * VA) begin
         n_fail++;
         $display("FAIL red_count: got %0d want %0d", red_n, HA * VA);
      end
      n_chk++;
      if (fs_n != 1) begin
         n_fail++;
         $display("FAIL fs_count: got %0d want 1", fs_n);
      end
   endtask

   task automatic test_sequencer();
      rst = 1'b0;
      vif.mode = 3'd0;
      vif.freeze = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int f = 0; f < 7; f++) begin
         for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec() !== exp_vec) begin
               n_fail++;
               $display("FAIL seq: got %h want %h n=%0d", dut_vec(), exp_vec, m_n);
            end
            if (i == 0) begin
               n_chk++;
               if (dut_rgb() !== SEQ[f]) begin
                  n_fail++;
                  $display("FAIL seq_frame%0d: got %h want %h", f, dut_rgb(), SEQ[f]);
               end
            end
         end
      end
   endtask

   task automatic test_freeze();
      rst = 1'b0;
      vif.mode = 3'd0;
      vif.freeze = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec() !== exp_vec) begin
               n_fail++;
               $display("FAIL freeze: got %h want %h n=%0d", dut_vec(), exp_vec, m_n);
            end
            if (i == 0) begin
               n_chk++;
               if (dut_rgb() !== FRZ[f]) begin
                  n_fail++;
                  $display("FAIL freeze_frame%0d: got %h want %h", f, dut_rgb(), FRZ[f]);
               end
            end
            if (i == FRAME / 2) vif.freeze = (f >= 3 && f <= 5);
         end
      end
      vif.freeze = 1'b0;
   endtask

   task automatic test_bars();
      int guard = 0;
      logic [11:0] want;
      vif.mode = 3'd1;
      do begin
         @(negedge clk);
         guard++;
         n_chk++;
         if (dut_vec() !== exp_vec) begin
            n_fail++;
            $display("FAIL bars_wait: got %h want %h", dut_vec(), exp_vec);
         end
      end while (!vif.frame_start && guard < 2 * FRAME);
      n_chk++;
      if (!vif.frame_start) begin
         n_fail++;
         $display("FAIL bars_fs_timeout: got 0 want 1");
      end
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec() !== exp_vec) begin
            n_fail++;
            $display("FAIL bars: got %h want %h n=%0d", dut_vec(), exp_vec, m_n);
         end
         if (i < HT) begin
            want = (i < HA) ? BARS[i / (HA / 8)] : 12'h000;
            n_chk++;
            if (dut_rgb() !== want) begin
               n_fail++;
               $display("FAIL bars_x%0d: got %h want %h", i, dut_rgb(), want);
            end
         end
      end
   endtask

   task automatic test_mode_change();
      int guard = 0;
      repeat (3 * HT + 4) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec() !== exp_vec) begin
            n_fail++;
            $display("FAIL mchg_pre: got %h want %h", dut_vec(), exp_vec);
         end
      end
      vif.mode = 3'd3;
      do begin
         @(negedge clk);
         guard++;
         n_chk++;
         if (dut_vec() !== exp_vec) begin
            n_fail++;
            $display("FAIL mchg_hold: got %h want %h", dut_vec(), exp_vec);
         end
      end while (!vif.frame_start && guard < 2 * FRAME);
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec() !== exp_vec) begin
            n_fail++;
            $display("FAIL checker: got %h want %h n=%0d", dut_vec(), exp_vec, m_n);
         end
         if (i == 0 || i == 2 || i == 2 * HT + 2) begin
            n_chk++;
            if (dut_rgb() !== ((i == 2) ? 12'h000 : 12'hFFF)) begin
               n_fail++;
               $display("FAIL checker_px%0d: got %h", i, dut_rgb());
            end
         end
         if (i == FRAME / 2) vif.mode = 3'd0;
      end
      guard = 0;
      while (!vif.frame_start && guard < 2 * FRAME) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      n_chk++;
      if (dut_rgb() !== 12'hF00) begin
         n_fail++;
         $display("FAIL seq_cleared: got %h want f00", dut_rgb());
      end
   endtask

   task automatic test_scroll();
      rst = 1'b0;
      vif.mode = 3'd2;
      vif.freeze = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int f = -1; f < 7; f++) begin
         for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec() !== exp_vec) begin
               n_fail++;
               $display("FAIL scroll: got %h want %h n=%0d", dut_vec(), exp_vec, m_n);
            end
            if (f >= 0 && i == 0) begin
               n_chk++;
               if (dut_rgb() !== SEQ[f]) begin
                  n_fail++;
                  $display("FAIL scroll_f%0d: got %h want %h", f, dut_rgb(), SEQ[f]);
               end
            end
            if ((f == 0 && i == 2 * HT) || (f == 1 && i == HT)) begin
               n_chk++;
               if (dut_rgb() !== 12'h0F0) begin
                  n_fail++;
                  $display("FAIL band_edge_f%0d: got %h want 0f0", f, dut_rgb());
               end
            end
         end
      end
   endtask

   task automatic test_random();
      repeat (6 * FRAME) begin
         if ($urandom_range(0, 99) == 0) vif.mode = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 49) == 0) vif.freeze = ~vif.freeze;
         @(negedge clk);
         n_chk++;
         if (dut_vec() !== exp_vec) begin
            n_fail++;
            $display("FAIL random: got %h want %h n=%0d", dut_vec(), exp_vec, m_n);
         end
      end
      vif.freeze = 1'b0;
   endtask

   task automatic test_pix_ce();
      int   n0;
      int   pulses = 0;
      logic prev_fs = 1'b0;
      n0 = m_n;
      repeat (12 * FRAME) begin
         vif.pix_ce = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         n_chk++;
         if (dut_vec() !== exp_vec) begin
            n_fail++;
            $display("FAIL pix_ce: got %h want %h n=%0d", dut_vec(), exp_vec, m_n);
         end
         n_chk++;
         if (vif.frame_start && prev_fs) begin
            n_fail++;
            $display("FAIL fs_width: got 2 clk want 1 clk");
         end
         if (vif.frame_start) pulses++;
         prev_fs = vif.frame_start;
      end
      n_chk++;
      if (pulses != m_n / FRAME - n0 / FRAME) begin
         n_fail++;
         $display("FAIL fs_pulses: got %0d want %0d", pulses, m_n / FRAME - n0 / FRAME);
      end
      vif.pix_ce = 1'b1;
   endtask

   task automatic test_mid_reset();
      vif.mode = 3'd3;
      repeat (FRAME + HT + 5) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec() !== exp_vec) begin
            n_fail++;
            $display("FAIL pre_reset: got %h want %h", dut_vec(), exp_vec);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (dut_vec() !== RST_VEC) begin
         n_fail++;
         $display("FAIL mid_reset: got %h want %h", dut_vec(), RST_VEC);
      end
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if (dut_vec() !== {~HP, ~VP, 2'b10, 12'hF00}) begin
         n_fail++;
         $display("FAIL restart_px0: got %h want %h", dut_vec(), {~HP, ~VP, 2'b10, 12'hF00});
      end
      repeat (FRAME) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec() !== exp_vec) begin
            n_fail++;
            $display("FAIL post_reset: got %h want %h", dut_vec(), exp_vec);
         end
      end
   endtask

   initial begin
      vif.pix_ce = 1'b1;
      vif.mode = 3'd0;
      vif.freeze = 1'b0;
      test_reset();
      test_timing();
      test_sequencer();
      test_freeze();
      test_bars();
      test_mode_change();
      test_scroll();
      test_random();
      test_pix_ce();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
